// File: rtl/obi_mem_responder_pkg.sv
// obi_mem_responder_pkg
//   Shared types and constants for the OBI memory responder slice.
//   - obi_resp_t : response record (rdata, err, rid, ruser) at the default
//                  parameter widths. The top builds an identically shaped
//                  record at its own parameter widths.
//   - LFSR_W / LFSR_SEED : grant-stall LFSR shape, used only when
//                  OBI_MEM_RESPONDER_GNT_STALL_EN is defined.
//   - offs_of() / OFFS : byte-offset bits dropped from a byte address to get
//                  a word index.
package obi_mem_responder_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ID_WIDTH   = 1;
  localparam int unsigned DEF_USER_WIDTH = 1;

  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic int unsigned offs_of(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  localparam int unsigned OFFS = offs_of(DEF_DATA_WIDTH);

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      err;
    logic [DEF_ID_WIDTH-1:0]   rid;
    logic [DEF_USER_WIDTH-1:0] ruser;
  } obi_resp_t;

endpackage

// File: rtl/obi_mem_responder_if.sv
// obi_mem_responder_if
//   OBI A-channel (req/gnt) and R-channel (rvalid/rready) signal bundle.
//   master modport: drives req, addr, we, be, wdata, auser, wuser, aid, rready.
//   slave  modport: drives gnt, rvalid, rdata, err, ruser, rid.
interface obi_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned USER_WIDTH = 1
) ();

  logic                    req;
  logic                    gnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [USER_WIDTH-1:0]   auser;
  logic [USER_WIDTH-1:0]   wuser;
  logic [ID_WIDTH-1:0]     aid;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;
  logic [USER_WIDTH-1:0]   ruser;
  logic [ID_WIDTH-1:0]     rid;

  modport master (
    output req, addr, we, be, wdata, auser, wuser, aid, rready,
    input  gnt, rvalid, rdata, err, ruser, rid
  );

  modport slave (
    input  req, addr, we, be, wdata, auser, wuser, aid, rready,
    output gnt, rvalid, rdata, err, ruser, rid
  );

endinterface

// File: rtl/obi_resp_fifo.sv
// obi_resp_fifo
//   Synchronous FIFO of response records, DEPTH entries (power of two, >= 1).
//   Ports: clk, reset_n (sync, active-low), push/din, pop/dout (head entry,
//   straight from storage registers), count, full, empty.
//   Push while full and pop while empty are ignored. Storage is cleared on
//   reset so the head reads as zero out of reset.
module obi_resp_fifo
  import obi_mem_responder_pkg::*;
#(
  parameter type         item_t = obi_resp_t,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  item_t                    din,
  input  logic                     pop,
  output item_t                    dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  item_t            store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else begin
      if (do_push) begin
        store[wr_ptr] <= din;
        wr_ptr        <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout  = store[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/obi_mem_responder.sv
// obi_mem_responder
//   OBI subordinate backed by a MEM_DEPTH x DATA_WIDTH word memory.
//   Ports: clk, reset_n (sync, active-low), bus (obi_mem_responder_if.slave).
//   A transfer is accepted on the edge where req & gnt; its response is pushed
//   into an in-order FIFO of MAX_OUTSTANDING entries and presented from the
//   FIFO head (rvalid = FIFO not empty), so the earliest response is one cycle
//   after acceptance. Addresses beyond the memory return err=1 with no write.
//   Optional: define OBI_MEM_RESPONDER_GNT_STALL_EN to add a 16-bit LFSR that
//   withholds gnt on roughly one cycle in four.
module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 1,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  obi_mem_responder_if.slave  bus
);

  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = offs_of(DATA_WIDTH);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic [ID_WIDTH-1:0]   rid;
    logic [USER_WIDTH-1:0] ruser;
  } resp_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  accept;
  logic                  pop;
  logic                  rst_done;
  logic                  stall;
  resp_t                 push_resp;
  resp_t                 head;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  unused_ok;

  assign idx      = bus.addr[OFFS_W +: IDX_W];
  // Every address bit above the word index must be zero to be in range.
  assign in_range = ((bus.addr >> (OFFS_W + IDX_W)) == '0);
  assign accept   = bus.req & bus.gnt;
  assign pop      = bus.rvalid & bus.rready;

  // Holds gnt low through reset and releases it on the first cycle after.
  always_ff @(posedge clk) begin
    if (!reset_n) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

`ifdef OBI_MEM_RESPONDER_GNT_STALL_EN
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign bus.gnt = rst_done & (count < CNT_W'(MAX_OUTSTANDING)) & ~stall;

  // Reset wins over a transfer presented on the reset edge.
  always_ff @(posedge clk) begin
    if (reset_n && accept && bus.we && in_range) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (bus.be[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    push_resp       = '0;
    push_resp.err   = ~in_range;
    push_resp.rid   = bus.aid;
    push_resp.ruser = bus.auser;
    if (in_range && !bus.we) push_resp.rdata = mem[idx];
  end

  obi_resp_fifo #(
    .item_t (resp_t),
    .DEPTH  (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .din     (push_resp),
    .pop     (pop),
    .dout    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign bus.rvalid = ~empty;
  assign bus.rdata  = head.rdata;
  assign bus.err    = head.err;
  assign bus.rid    = head.rid;
  assign bus.ruser  = head.ruser;

  assign unused_ok = ^{bus.wuser, full};

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb_obi_mem_responder
//   Directed and randomized bench for obi_mem_responder (ID_WIDTH=2, other
//   parameters at defaults). A reference model holds memory as an associative
//   array of words and outstanding responses as a queue; it is updated on the
//   falling edge from the bus values that the next rising edge will sample.
//   Define OBI_MEM_RESPONDER_GNT_STALL_EN for both bench and RTL to run the
//   grant-stall ratio check.
module tb_obi_mem_responder;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned IW      = 2;
  localparam int unsigned UW      = 1;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned MAX_OUT = 2;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic [IW-1:0] rid;
    logic [UW-1:0] ruser;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  obi_mem_responder_if #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .USER_WIDTH (UW)
  ) bus ();

  obi_mem_responder #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .ID_WIDTH        (IW),
    .USER_WIDTH      (UW),
    .MEM_DEPTH       (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t          q[$];
  logic [DW-1:0] model_mem [longint];
  bit            model_rst_done = 1'b0;
  bit            sb_en = 1'b0;
  bit            stall_win = 1'b0;
  int            win_cycles = 0;
  int            win_low = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: checks current outputs, then applies the coming edge.
  always @(negedge clk) begin
    if (sb_en) begin
      automatic exp_t e;
      automatic longint widx;
      chk("rvalid", 64'(bus.rvalid), 64'(q.size() != 0));
`ifdef OBI_MEM_RESPONDER_GNT_STALL_EN
      chk("gnt_only_when_room", 64'(bus.gnt & ~(model_rst_done & (q.size() < MAX_OUT))), 64'd0);
      if (stall_win) begin
        win_cycles++;
        if (!bus.gnt) win_low++;
      end
`else
      chk("gnt", 64'(bus.gnt), 64'(model_rst_done && (q.size() < MAX_OUT)));
`endif
      if (bus.rvalid && q.size() != 0) begin
        chk("rdata", 64'(bus.rdata), 64'(q[0].rdata));
        chk("err",   64'(bus.err),   64'(q[0].err));
        chk("rid",   64'(bus.rid),   64'(q[0].rid));
        chk("ruser", 64'(bus.ruser), 64'(q[0].ruser));
      end
      if (!reset_n) begin
        q.delete();
        model_rst_done = 1'b0;
      end else begin
        if (bus.rvalid && bus.rready && q.size() != 0) void'(q.pop_front());
        if (bus.req && bus.gnt) begin
          widx    = longint'(bus.addr) / (DW / 8);
          e.rid   = bus.aid;
          e.ruser = bus.auser;
          e.rdata = '0;
          e.err   = 1'b0;
          if (widx >= DEPTH) begin
            e.err = 1'b1;
          end else if (bus.we) begin
            if (!model_mem.exists(widx)) model_mem[widx] = 'x;
            for (int b = 0; b < DW / 8; b++) begin
              if (bus.be[b]) model_mem[widx][8*b +: 8] = bus.wdata[8*b +: 8];
            end
          end else begin
            e.rdata = model_mem.exists(widx) ? model_mem[widx] : 'x;
          end
          q.push_back(e);
        end
        model_rst_done = 1'b1;
      end
    end
  end

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW/8-1:0] b,
                       input logic [DW-1:0] d, input logic [IW-1:0] id, input bit rnd_rr);
    logic g;
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.be    = b;
    bus.wdata = d;
    bus.aid   = id;
    bus.auser = UW'($urandom_range(0, 1));
    bus.wuser = UW'($urandom_range(0, 1));
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      g = bus.gnt;
      @(posedge clk);
      #1;
      if (rnd_rr) bus.rready = 1'($urandom_range(0, 1));
      if (g === 1'b1) begin
        bus.req = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $error("FAIL issue_timeout: addr %0h never granted, required grant within 200 cycles", a);
    bus.req = 1'b0;
  endtask

  task automatic drain();
    bus.rready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $error("FAIL drain_timeout: %0d responses still queued, required 0", q.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = '0;
    bus.be     = '0;
    bus.wdata  = '0;
    bus.auser  = '0;
    bus.wuser  = '0;
    bus.aid    = '0;
    bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb_en   = 1'b1;
    chk("reset_rvalid", 64'(bus.rvalid), 64'd0);
    chk("reset_rdata",  64'(bus.rdata),  64'd0);
    chk("reset_err",    64'(bus.err),    64'd0);
    chk("reset_rid",    64'(bus.rid),    64'd0);
    chk("reset_ruser",  64'(bus.ruser),  64'd0);
    chk("reset_gnt",    64'(bus.gnt),    64'd0);
    @(posedge clk);
    #1;
    chk("gnt_after_release", 64'(bus.gnt), 64'd1);

    // Write then read, plus a known word 0 for later checks.
    bus.rready = 1'b1;
    issue(1'b1, 32'h0,  4'hF, 32'h1234_5678, 2'd0, 1'b0);
    issue(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 2'd1, 1'b0);
    issue(1'b0, 32'h10, 4'hF, 32'h0,         2'd1, 1'b0);
    drain();

    // Partial byte enables; read with be=0 still returns the full word.
    issue(1'b1, 32'h20, 4'hF,    32'h1122_3344, 2'd2, 1'b0);
    issue(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 2'd3, 1'b0);
    issue(1'b0, 32'h20, 4'h0,    32'h0,         2'd0, 1'b0);
    drain();
    chk("partial_be_model", 64'(model_mem[8]), 64'h11BB_33DD);

    // Backpressure: third read must wait until the first response pops.
    bus.rready = 1'b0;
    issue(1'b0, 32'h10, 4'hF, 32'h0, 2'd0, 1'b0);
    issue(1'b0, 32'h21, 4'hF, 32'h0, 2'd1, 1'b0);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'h0;
    bus.aid  = 2'd2;
    repeat (3) begin
      @(negedge clk);
      chk("gnt_low_when_full", 64'(bus.gnt), 64'd0);
      chk("rid_head_held", 64'(bus.rid), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.rready = 1'b1;
    issue(1'b0, 32'h0, 4'hF, 32'h0, 2'd2, 1'b0);
    drain();

    // Out-of-range write leaves word 0 alone.
    issue(1'b1, 32'(DEPTH * 4), 4'hF, 32'hFFFF_FFFF, 2'd1, 1'b0);
    issue(1'b0, 32'h0, 4'hF, 32'h0, 2'd2, 1'b0);
    issue(1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, 2'd3, 1'b0);
    drain();

    // Reset with two responses queued.
    bus.rready = 1'b0;
    issue(1'b0, 32'h10, 4'hF, 32'h0, 2'd1, 1'b0);
    issue(1'b0, 32'h20, 4'hF, 32'h0, 2'd2, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("midreset_rvalid", 64'(bus.rvalid), 64'd0);
    chk("midreset_gnt",    64'(bus.gnt),    64'd0);
    @(posedge clk);
    #1;
    chk("midreset_gnt_release", 64'(bus.gnt), 64'd1);
    bus.rready = 1'b1;
    issue(1'b0, 32'h10, 4'hF, 32'h0, 2'd3, 1'b0);
    drain();

    // Randomized traffic over words 0..15 with occasional out-of-range.
    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 4'hF, $urandom, 2'(i), 1'b0);
    drain();
    for (int i = 0; i < 300; i++) begin
      automatic logic [AW-1:0] a;
      if ($urandom_range(0, 7) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
      else                           a = 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 2'($urandom), 1'b1);
    end
    drain();

`ifdef OBI_MEM_RESPONDER_GNT_STALL_EN
    bus.rready = 1'b1;
    stall_win  = 1'b1;
    for (int i = 0; i < 1000; i++) issue(1'b0, 32'($urandom_range(0, 63)), 4'hF, 32'h0, 2'($urandom), 1'b0);
    stall_win = 1'b0;
    drain();
    chk("stall_ratio_20_30pct",
        64'((win_low * 100 >= win_cycles * 20) && (win_low * 100 <= win_cycles * 30)), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
